// File: rtl/img_rom_pkg.sv
// -----------------------------------------------------------------------------
// img_rom_pkg
// Shared constants and the response-tag type for the image ROM arbiter.
//   IMG_X_W / IMG_Y_W : coordinate widths
//   PIX_W             : RGBA pixel width, R[15:12] G[11:8] B[7:4] A[3:0]
//   tag_t             : {valid, oob, idx} carried alongside each ROM read
// -----------------------------------------------------------------------------
package img_rom_pkg;

    localparam int unsigned IMG_X_W   = 10;
    localparam int unsigned IMG_Y_W   = 9;
    localparam int unsigned PIX_W     = 16;
    // Wide enough for the largest supported requester count (8).
    localparam int unsigned TAG_IDX_W = 3;

    localparam logic [PIX_W-1:0] PIX_TRANSPARENT = 16'h0000;

    typedef struct packed {
        logic                 valid;
        logic                 oob;
        logic [TAG_IDX_W-1:0] idx;
    } tag_t;

    // Requester index width, never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/img_rom_arbiter_if.sv
// -----------------------------------------------------------------------------
// img_rom_arbiter_if
// Requester-side bus of the image ROM arbiter.
//   req       : per-requester level request
//   req_x/y   : packed coordinates, requester i at [i*W +: W]
//   gnt       : one-hot grant
//   rsp_valid : one-hot response strobe
//   rsp_pixel : returned pixel, shared by all requesters
// Modports: master = display fetchers, slave = arbiter.
// -----------------------------------------------------------------------------
interface img_rom_arbiter_if #(
    parameter int unsigned NUM_REQ = 3
);
    import img_rom_pkg::*;

    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*IMG_X_W-1:0] req_x;
    logic [NUM_REQ*IMG_Y_W-1:0] req_y;
    logic [NUM_REQ-1:0]         gnt;
    logic [NUM_REQ-1:0]         rsp_valid;
    logic [PIX_W-1:0]           rsp_pixel;

    modport master (
        output req, req_x, req_y,
        input  gnt, rsp_valid, rsp_pixel
    );

    modport slave (
        input  req, req_x, req_y,
        output gnt, rsp_valid, rsp_pixel
    );

endinterface

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: first set request at or above i_ptr, wrapping.
//   i_req : request vector
//   i_ptr : search start index (< N)
//   o_gnt : one-hot grant, zero when i_req is zero
//   o_idx : binary index of the grant (0 when no grant)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_idx
);

    logic             w_found;
    logic [IDX_W:0]   w_cand;

    // Walk candidates ptr, ptr+1, ... mod N; one spare bit keeps the sum from wrapping.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < int'(N); k++) begin
            w_cand = {1'b0, i_ptr} + (IDX_W+1)'(k);
            if (w_cand >= (IDX_W+1)'(N)) begin
                w_cand = w_cand - (IDX_W+1)'(N);
            end
            for (int i = 0; i < int'(N); i++) begin
                if (!w_found && i_req[i] && (w_cand == (IDX_W+1)'(i))) begin
                    w_found  = 1'b1;
                    o_gnt[i] = 1'b1;
                    o_idx    = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/img_rom_arbiter.sv
// -----------------------------------------------------------------------------
// img_rom_arbiter
// Shares one registered-output RGBA ROM reader among NUM_REQ requesters.
// Round-robin, one coordinate per clk; each issue is tagged and the pixel that
// returns READ_LAT clk later is steered back to the originating requester.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus        : requester bus (slave modport)
//   rom_x/y    : coordinate to the reader (held when idle)
//   rom_pixel  : pixel from the reader
// Optional: define IMG_ROM_ARB_BOUNDS_CHECK_EN to return transparent pixels for
// coordinates outside WIDTH x HEIGHT without moving the ROM address.
// -----------------------------------------------------------------------------
module img_rom_arbiter
    import img_rom_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 3,
    parameter int unsigned WIDTH    = 300,
    parameter int unsigned HEIGHT   = 250,
    parameter int unsigned READ_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    img_rom_arbiter_if.slave   bus,
    output logic [IMG_X_W-1:0] rom_x,
    output logic [IMG_Y_W-1:0] rom_y,
    input  logic [PIX_W-1:0]   rom_pixel
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);

    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IMG_X_W-1:0] r_hold_x;
    logic [IMG_Y_W-1:0] r_hold_y;
    tag_t               r_tag [READ_LAT];

    logic [NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0] w_gnt;
    logic [IDX_W-1:0]   w_idx;
    logic               w_xfer;
    logic               w_issue;
    logic               w_oob;
    logic [IMG_X_W-1:0] w_gx;
    logic [IMG_Y_W-1:0] w_gy;

    // Requests are ignored while in reset.
    assign w_req = rst ? '0 : bus.req;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .i_req (w_req),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

    assign bus.gnt = w_gnt;
    assign w_xfer  = |w_gnt;

    // Granted requester's coordinates.
    always_comb begin
        w_gx = '0;
        w_gy = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (w_gnt[i]) begin
                w_gx = bus.req_x[i*IMG_X_W +: IMG_X_W];
                w_gy = bus.req_y[i*IMG_Y_W +: IMG_Y_W];
            end
        end
    end

    assign w_oob = (w_gx >= IMG_X_W'(WIDTH)) || (w_gy >= IMG_Y_W'(HEIGHT));

`ifdef IMG_ROM_ARB_BOUNDS_CHECK_EN
    // Out-of-range transfers leave the ROM address where it was.
    assign w_issue = w_xfer & ~w_oob;
`else
    assign w_issue = w_xfer;
`endif

    assign rom_x = w_issue ? w_gx : r_hold_x;
    assign rom_y = w_issue ? w_gy : r_hold_y;

    // Pointer, held address and tag pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
            r_hold_x <= '0;
            r_hold_y <= '0;
            for (int s = 0; s < int'(READ_LAT); s++) begin
                r_tag[s] <= '0;
            end
        end else begin
            if (w_xfer) begin
                r_rr_ptr <= (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + IDX_W'(1);
            end
            if (w_issue) begin
                r_hold_x <= w_gx;
                r_hold_y <= w_gy;
            end
            r_tag[0].valid <= w_xfer;
            r_tag[0].oob   <= w_xfer & w_oob;
            r_tag[0].idx   <= TAG_IDX_W'(w_idx);
            for (int s = 1; s < int'(READ_LAT); s++) begin
                r_tag[s] <= r_tag[s-1];
            end
        end
    end

    // Response steering from the last tag stage; silent during reset.
    always_comb begin
        bus.rsp_valid = '0;
        bus.rsp_pixel = PIX_TRANSPARENT;
        if (!rst && r_tag[READ_LAT-1].valid) begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                bus.rsp_valid[i] = (r_tag[READ_LAT-1].idx == TAG_IDX_W'(i));
            end
`ifdef IMG_ROM_ARB_BOUNDS_CHECK_EN
            bus.rsp_pixel = r_tag[READ_LAT-1].oob ? PIX_TRANSPARENT : rom_pixel;
`else
            bus.rsp_pixel = rom_pixel;
`endif
        end
    end

endmodule
